uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-level UART transmitter between NUM_REQ requesters; each requester sends a packet, which is one or more bytes ending with a last flag.
- Sits between producer blocks (debug dumper, status reporter, echo path) and the UART TX byte engine, which accepts a byte on valid&ready.
- Round-robin grant per packet, with no interleaving of bytes from different requesters.
- Enforces an idle gap between packets and a stall timeout so a dead requester cannot hold the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 234, idle clocks between the end of one packet and the next grant; default is one bit time at DELAY_FRAMES=234.
- TIMEOUT_CYCLES, 65535, clocks the granted requester may hold valid low mid-packet before the packet is aborted.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-low
- i_req_valid  in  NUM_REQ  per-requester byte valid
- i_req_data  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- i_req_last  in  NUM_REQ  byte is the final byte of its packet
- o_req_ready  out  NUM_REQ  byte accepted from requester k this cycle
- o_tx_data  out  8  byte to UART TX engine
- o_tx_valid  out  1  byte valid to UART TX engine
- i_tx_ready  in  1  UART TX engine can accept a byte
- o_grant  out  NUM_REQ  one-hot current owner; all zeros when none
- o_busy  out  1  high in any state other than IDLE
- o_abort  out  1  one-cycle pulse when a packet is aborted by timeout

Behaviour:
- Reset, asynchronous, i_rst=0:
  - state IDLE; o_grant=0, o_busy=0, o_abort=0, o_tx_valid=0, o_req_ready=0, o_tx_data=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first. Timers = 0.
- States: IDLE, GRANT, FWD, GAP (plus TAG when the optional feature is compiled in).
- IDLE:
  - When any i_req_valid is high, register the winner into o_grant and go to GRANT.
  - The winner is the first set bit searching upward from pointer+1, with wrap-around.
- GRANT: one cycle; pointer <= winner index; go to FWD.
- FWD:
  - Combinational pass-through of the owner:
    - o_tx_valid = i_req_valid[g]
    - o_tx_data = i_req_data[g]
    - o_req_ready = o_grant & {NUM_REQ{i_tx_ready}}
  - Non-owners see ready=0.
  - A transfer occurs on i_req_valid[g] & i_tx_ready.
  - On a transfer with i_req_last[g]=1: clear o_grant, reset the gap timer, go to GAP.
  - Stall timer clears on every transfer and counts while i_req_valid[g]=0.
  - When the stall timer reaches TIMEOUT_CYCLES-1: pulse o_abort, clear o_grant, go to GAP.
  - Stalls caused by i_tx_ready=0 do not count toward timeout.
- GAP:
  - o_tx_valid=0. Count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES=0, go to IDLE the next cycle.
- Latency: a request in IDLE gives its first byte on o_tx_valid two cycles after i_req_valid rises (IDLE->GRANT->FWD).
- Simultaneous requests: resolved only by the round-robin pointer.
  - A requester that has just been served has the lowest priority for the next grant.
- Owner's valid dropping mid-packet is legal and keeps ownership until timeout.
- A requester raising valid while another owns the line waits; no byte is dropped.
- Reset mid-packet: immediate return to IDLE; the partial packet is lost; the TX engine is expected to be reset by the same i_rst.
- Timer widths: $clog2 of the respective limit + 1; no wrap occurs before the compare.

Optional Feature:
- Macro UART_ARB_TAG_EN.
- Defined:
  - GRANT goes to TAG instead of FWD.
  - TAG drives o_tx_valid=1, o_tx_data = 8'hA0 | winner index, o_req_ready=0.
  - On i_tx_ready, go to FWD.
  - The receiver can then identify the source of each packet.
- Undefined: no TAG state; GRANT goes directly to FWD.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants;
  - TAG_BASE=8'hA0;
  - DELAY_FRAMES default (234), shared with the UART engines.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index, any-request flag.
- The FSM, timers and mux stay in uart_tx_arbiter.

Test Plan:
- Single packet: req0 sends "hi" (8'h68, 8'h69 with last), i_tx_ready=1 -> o_tx_data 68 then 69; o_grant=0001 during FWD; GAP lasts 234 cycles; then IDLE.
- Contention: req0, req1 and req2 all valid with 1-byte packets -> service order 0,1,2; next round with all three valid again -> order 0,1,2 (rotation, not a fixed-priority repeat).
- Backpressure: i_tx_ready low for 50 cycles mid-packet -> data held stable, no o_abort, all bytes delivered exactly once.
- Timeout: TIMEOUT_CYCLES=100; req1 sends one byte without last, then drops valid -> o_abort pulses exactly once, 100 cycles after the last transfer; next grant goes to waiting req2.
- Reset mid-packet: assert i_rst=0 during FWD -> outputs zero asynchronously; after release, requester 0 wins first.
- UART_ARB_TAG_EN: req3 packet 8'h55 (last) -> o_tx_data sequence A3, 55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: arbiter state encodings, source-tag base and the
// default bit-time in clocks used by the UART engines.
package uart_pkg;

  localparam int DELAY_FRAMES = 234;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_GRANT = 3'd1;
  localparam state_t ST_FWD   = 3'd2;
  localparam state_t ST_GAP   = 3'd3;
  localparam state_t ST_TAG   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping around, so the last winner has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = |i_req;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(i_ptr) + i) % 32'(NUM_REQ));
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_onehot[cand] = 1'b1;
        o_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte engine.
// Define UART_ARB_TAG_EN to prefix each packet with a source tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DELAY_FRAMES,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_abort
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int GAP_W   = $clog2(GAP_CYCLES) + 1;
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 abort_q, abort_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (ptr_q),
    .o_onehot (pick_onehot),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign own_data  = i_req_data[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    stall_d = stall_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          stall_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        ptr_d = owner_q;
`ifdef UART_ARB_TAG_EN
        state_d = ST_TAG;
`else
        state_d = ST_FWD;
`endif
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        if (i_tx_ready) state_d = ST_FWD;
      end
`endif
      ST_FWD: begin
        if (own_valid && i_tx_ready) begin
          stall_d = '0;
          if (own_last) begin
            grant_d = '0;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end else if (!own_valid) begin
          // Only an absent owner counts as a stall; engine backpressure never does.
          if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            abort_d = 1'b1;
            grant_d = '0;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (32'(gap_q) + 32'd1 >= 32'(GAP_CYCLES)) state_d = ST_IDLE;
        else                                       gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    case (state_q)
      ST_FWD: begin
        o_tx_valid  = own_valid;
        o_tx_data   = own_data;
        o_req_ready = grant_q & {NUM_REQ{i_tx_ready}};
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        o_tx_valid = 1'b1;
        o_tx_data  = TAG_BASE | 8'(owner_q);
      end
`endif
      default: ;
    endcase
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_abort = abort_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gap_q   <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

endmodule
